// File: rtl/ysyx_22041207_ifu_if.sv
// Instruction-memory bus between the fetch unit and instruction memory:
// a valid/ready request channel and a valid-only response channel.
interface ysyx_22041207_ifu_if;
    localparam int unsigned XLEN = 64;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: one outstanding imem request, one buffered
// instruction for IF/ID, redirect with squash of in-flight fetches.
module ysyx_22041207_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    ysyx_22041207_ifu_if.master   imem,
    output logic [31:0]           inst_o,
    output logic [63:0]           pc_o,
    output logic                  inst_valid_o
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] pc_o_d;
    logic [ILEN-1:0] inst_buf, inst_buf_d;
    logic            inst_valid_d;
    logic            drop, drop_d;
    logic [ILEN-1:0] resp_word;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_low;

    assign unused_redirect_low = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};

    assign imem.imem_req_valid = (state == S_REQ);
    assign imem.imem_addr      = {pc[XLEN-1:3], 3'b000};

    // pc[2] picks which half of the aligned doubleword holds the instruction
    assign resp_word = pc[2] ? imem.imem_resp_data[63:32] : imem.imem_resp_data[31:0];
    assign inst_o    = inst_valid_o ? inst_buf : NOP_INST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            pc_o         <= RESET_PC;
            inst_buf     <= NOP_INST;
            inst_valid_o <= 1'b0;
            drop         <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            pc_o         <= pc_o_d;
            inst_buf     <= inst_buf_d;
            inst_valid_o <= inst_valid_d;
            drop         <= drop_d;
        end
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        pc_o_d       = pc_o;
        inst_buf_d   = inst_buf;
        inst_valid_d = inst_valid_o;
        drop_d       = drop;

        if (redirect_valid) begin
            // Redirect wins; any request already accepted must have its response dropped
            pc_d         = redirect_target;
            inst_valid_d = 1'b0;
            case (state)
                S_REQ: begin
                    if (imem.imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem.imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        if (drop) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_buf_d   = resp_word;
                            pc_o_d       = pc;
                            inst_valid_d = 1'b1;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_valid_d = 1'b0;
                        pc_d         = pc + XLEN'(4);
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Directed bench for ysyx_22041207_ifu with a small instruction-memory model.
module tb_ysyx_22041207_ifu;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        inst_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    // memory model controls and bookkeeping
    logic        mem_ready  = 1'b1;
    int          resp_delay = 1;
    logic        pending    = 1'b0;
    int          cnt        = 0;
    logic [63:0] pending_addr;
    int          req_count  = 0;
    logic [63:0] last_req_addr;

    ysyx_22041207_ifu_if bus();

    ysyx_22041207_ifu #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .inst_valid_o   (inst_valid_o)
    );

    always #5 clk = ~clk;

    // Each word of a doubleword holds its own address, except the reset line.
    function automatic logic [63:0] mem_read(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        if (a == 64'h0000_0000_8000_0000) return 64'h00500093_00100093;
        return {lo + 32'd4, lo};
    endfunction

    // Drives memory-side signals on the falling edge, away from the DUT's sampling edge.
    always @(negedge clk) begin
        bus.imem_resp_valid = 1'b0;
        if (pending) begin
            if (cnt <= 1) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_read(pending_addr);
                pending = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        bus.imem_req_ready = mem_ready;
        if (rst_n && bus.imem_req_valid && mem_ready) begin
            pending       = 1'b1;
            cnt           = resp_delay;
            pending_addr  = bus.imem_addr;
            last_req_addr = bus.imem_addr;
            req_count     = req_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
        n_cmp++; if (pc_o !== RESET_PC) begin n_err++; $display("FAIL reset_pc_o: got %h want %h", pc_o, RESET_PC); end
        n_cmp++; if (inst_o !== NOP_INST) begin n_err++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP_INST); end
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL reset_req_valid: got %b want 1", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RESET_PC); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_fetch();
        tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait_req: got %b want 0", bus.imem_req_valid); end
        tick();
        n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid0: got %b want 1", inst_valid_o); end
        n_cmp++; if (inst_o !== 32'h00100093) begin n_err++; $display("FAIL basic_inst0: got %h want 00100093", inst_o); end
        n_cmp++; if (pc_o !== 64'h8000_0000) begin n_err++; $display("FAIL basic_pc0: got %h want 80000000", pc_o); end
        tick();
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_accept: got %b want 0", inst_valid_o); end
        n_cmp++; if (bus.imem_addr !== 64'h8000_0000) begin n_err++; $display("FAIL basic_addr1: got %h want 80000000", bus.imem_addr); end
        tick(); tick();
        n_cmp++; if (inst_o !== 32'h00500093) begin n_err++; $display("FAIL basic_inst1: got %h want 00500093", inst_o); end
        n_cmp++; if (pc_o !== 64'h8000_0004) begin n_err++; $display("FAIL basic_pc1: got %h want 80000004", pc_o); end
        tick();
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 64'h8000_0008) begin
            n_err++; $display("FAIL basic_addr2: got %b/%h want 1/80000008", bus.imem_req_valid, bus.imem_addr); end
        n_cmp++; if (inst_o !== NOP_INST) begin n_err++; $display("FAIL basic_nop: got %h want %h", inst_o, NOP_INST); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick(); tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8000_0008) begin
            n_err++; $display("FAIL stall_capture: got %b/%h want 1/80000008", inst_valid_o, inst_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8000_0008 || pc_o !== 64'h8000_0008 || bus.imem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL stall_hold%0d: got %b/%h/%h/%b want 1/80000008/80000008/0", i, inst_valid_o, inst_o, pc_o, bus.imem_req_valid); end
        end
        stall = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (inst_o !== 32'h8000_000C || pc_o !== 64'h8000_000C) begin
            n_err++; $display("FAIL stall_advance: got %h/%h want 8000000c/8000000c", inst_o, pc_o); end
    endtask

    task automatic test_redirect_wait();
        tick();
        resp_delay = 2;
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (inst_valid_o !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL rw_wait: got %b/%b want 0/0", inst_valid_o, bus.imem_req_valid); end
        tick();
        resp_delay = 1;
        n_cmp++; if (inst_valid_o !== 1'b0 || bus.imem_addr !== 64'h8000_1000 || bus.imem_req_valid !== 1'b1) begin
            n_err++; $display("FAIL rw_drop: got %b/%h/%b want 0/80001000/1", inst_valid_o, bus.imem_addr, bus.imem_req_valid); end
        tick(); tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8000_1000 || pc_o !== 64'h8000_1000) begin
            n_err++; $display("FAIL rw_deliver: got %b/%h/%h want 1/80001000/80001000", inst_valid_o, inst_o, pc_o); end
    endtask

    task automatic test_redirect_handshake();
        int base;
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        base = req_count;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rh_squash: got %b want 0", inst_valid_o); end
        tick();
        n_cmp++; if (inst_valid_o !== 1'b0 || bus.imem_addr !== 64'h8000_2000) begin
            n_err++; $display("FAIL rh_drop: got %b/%h want 0/80002000", inst_valid_o, bus.imem_addr); end
        tick(); tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8000_2000 || pc_o !== 64'h8000_2000) begin
            n_err++; $display("FAIL rh_deliver: got %b/%h/%h want 1/80002000/80002000", inst_valid_o, inst_o, pc_o); end
        n_cmp++; if (req_count - base !== 2 || last_req_addr !== 64'h8000_2000) begin
            n_err++; $display("FAIL rh_reqs: got %0d/%h want 2/80002000", req_count - base, last_req_addr); end
    endtask

    task automatic test_redirect_resp();
        int base;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        base = req_count;
        n_cmp++; if (inst_valid_o !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 64'h8000_3000) begin
            n_err++; $display("FAIL rr_discard: got %b/%b/%h want 0/1/80003000", inst_valid_o, bus.imem_req_valid, bus.imem_addr); end
        tick(); tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8000_3000 || pc_o !== 64'h8000_3000) begin
            n_err++; $display("FAIL rr_deliver: got %b/%h/%h want 1/80003000/80003000", inst_valid_o, inst_o, pc_o); end
        n_cmp++; if (req_count - base !== 1) begin n_err++; $display("FAIL rr_reqs: got %0d want 1", req_count - base); end
    endtask

    task automatic test_ready_low();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 64'h8000_3000 || inst_valid_o !== 1'b0 || inst_o !== NOP_INST) begin
                n_err++; $display("FAIL rl_hold%0d: got %b/%h/%b/%h want 1/80003000/0/%h", i, bus.imem_req_valid, bus.imem_addr, inst_valid_o, inst_o, NOP_INST); end
        end
        mem_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8000_3004 || pc_o !== 64'h8000_3004) begin
            n_err++; $display("FAIL rl_deliver: got %b/%h/%h want 1/80003004/80003004", inst_valid_o, inst_o, pc_o); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (inst_valid_o !== 1'b0 || bus.imem_addr !== 64'h8000_4000) begin
            n_err++; $display("FAIL rs_squash: got %b/%h want 0/80004000", inst_valid_o, bus.imem_addr); end
        tick(); tick(); tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8000_4000 || pc_o !== 64'h8000_4000) begin
            n_err++; $display("FAIL rs_held: got %b/%h/%h want 1/80004000/80004000", inst_valid_o, inst_o, pc_o); end
        stall = 1'b0;
        tick();
        n_cmp++; if (inst_valid_o !== 1'b0 || bus.imem_addr !== 64'h8000_4000 || bus.imem_req_valid !== 1'b1) begin
            n_err++; $display("FAIL rs_release: got %b/%h/%b want 0/80004000/1", inst_valid_o, bus.imem_addr, bus.imem_req_valid); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            n_err++; $display("FAIL wrap_addr: got %h want fffffffffffffff8", bus.imem_addr); end
        tick(); tick();
        n_cmp++; if (inst_o !== 32'hFFFF_FFFC || pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++; $display("FAIL wrap_inst: got %h/%h want fffffffc/fffffffffffffffc", inst_o, pc_o); end
        tick();
        n_cmp++; if (bus.imem_addr !== 64'h0 || bus.imem_req_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc: got %h/%b want 0/1", bus.imem_addr, bus.imem_req_valid); end
    endtask

    task automatic test_reset_mid_wait();
        resp_delay = 2;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (inst_valid_o !== 1'b0 || pc_o !== RESET_PC || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            n_err++; $display("FAIL rm_reset: got %b/%h/%b/%h want 0/%h/1/%h", inst_valid_o, pc_o, bus.imem_req_valid, bus.imem_addr, RESET_PC, RESET_PC); end
        tick();
        resp_delay = 1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (inst_valid_o !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_stale: got %b/%b want 0/0", inst_valid_o, bus.imem_req_valid); end
        tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00100093 || pc_o !== RESET_PC) begin
            n_err++; $display("FAIL rm_restart: got %b/%h/%h want 1/00100093/%h", inst_valid_o, inst_o, pc_o, RESET_PC); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_redirect_resp();
        test_ready_low();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_22041207_ifu.md
Name: ysyx_22041207_ifu

Overview:
Instruction fetch unit directly upstream of the IF/ID pipeline register. Holds the architectural fetch PC and issues one request at a time to instruction memory over a valid/ready request channel plus a valid-only response channel. Buffers one fetched instruction and presents it with its PC to IF/ID; the downstream stall (bubble) holds that instruction. Accepts branch/jump redirects from later stages and squashes in-flight fetches.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction driven on inst_o when no valid instruction is buffered (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
stall  in  1  downstream bubble; 1 = IF/ID not accepting this cycle
redirect_valid  in  1  control-flow redirect request
redirect_pc  in  64  redirect target; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  64  request address, 8-byte aligned ({pc[63:3],3'b0})
imem_resp_valid  in  1  response data valid, one cycle per accepted request
imem_resp_data  in  64  aligned doubleword
inst_o  out  32  instruction to IF/ID
pc_o  out  64  PC of inst_o
inst_valid_o  out  1  inst_o/pc_o hold a real fetched instruction

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=S_REQ, inst_buf=NOP_INST, inst_valid_o=0, drop=0, pc_o=RESET_PC. Outputs: imem_req_valid=1 one cycle after reset deasserts is not required; asserted combinationally whenever state=S_REQ, including while reset is deasserted.
- inst_o = inst_valid_o ? inst_buf : NOP_INST; pc_o = registered PC of buffered instruction.
- Instruction select: inst_buf <= pc[2] ? resp_data[63:32] : resp_data[31:0].
- At most one outstanding request. State machine:
  - S_REQ: imem_req_valid=1, imem_addr from pc. req_ready=1 -> S_WAIT. imem_resp_valid ignored in S_REQ.
  - S_WAIT: imem_req_valid=0. On resp_valid: if drop=1, discard data, clear drop, -> S_REQ. Else inst_buf<=selected word, pc_o<=pc, inst_valid_o<=1, -> S_HOLD.
  - S_HOLD: imem_req_valid=0. Instruction accepted in any cycle with stall=0: inst_valid_o<=0, pc<=pc+4 (mod 2^64, wraps), -> S_REQ. stall=1: all holds.
- Latency: resp in cycle N -> inst_valid_o=1 from cycle N+1; minimum 3 cycles per instruction with 1-cycle memory.
- Redirect (priority over all other transitions at the same edge): pc<={redirect_pc[63:2],2'b00}; inst_valid_o<=0 (squash buffered instruction even if stall=1).
  - S_REQ, req_ready=0: stay S_REQ (next request uses new pc).
  - S_REQ, req_ready=1 same cycle: request with old pc was accepted -> S_WAIT, drop<=1.
  - S_WAIT, no resp this cycle: stay S_WAIT, drop<=1.
  - S_WAIT, resp this cycle: discard data -> S_REQ, drop<=0.
  - S_HOLD: -> S_REQ.
- Redirect while stall=1: still taken; fetch of new target proceeds; resulting instruction held in S_HOLD until stall=0.
- pc+4 and redirect never touch pc_o until a new instruction is captured.

Test Plan:
- Reset release, memory ready=1, 1-cycle response, data 64'h00500093_00100093, stall=0 -> imem_addr=0x80000000; inst_o=0x00100093 pc_o=0x80000000, then 0x00500093 pc_o=0x80000004, then addr 0x80000008.
- Stall=1 for 5 cycles while in S_HOLD -> inst_o/pc_o/inst_valid_o constant, imem_req_valid=0, pc not incremented; release -> pc advances by exactly 4.
- Redirect to 0x80001002 in S_WAIT, response 2 cycles later -> response discarded, inst_valid_o stays 0, next imem_addr=0x80001000, delivered pc_o=0x80001000.
- Redirect in same cycle as req handshake, and separately in same cycle as resp_valid -> no instruction from old pc ever appears with inst_valid_o=1; exactly one request to new target.
- req_ready held low 4 cycles -> imem_req_valid and imem_addr stable until handshake; inst_o=NOP_INST with inst_valid_o=0.
- Assert rst_n=0 mid-S_WAIT, then stale resp_valid after release -> outputs return to reset values immediately; stale response ignored; fetch restarts at 0x80000000.
